// File: rtl/sonar_medidor_bcd_if.sv
// Sensor-side bundle of one HC-SR04 measurement channel.
interface sonar_medidor_bcd_if;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    modport master (
        output medir, echo,
        input  trigger, medida, pronto, erro, db_estado
    );

    modport slave (
        input  medir, echo,
        output trigger, medida, pronto, erro, db_estado
    );
endinterface

// File: rtl/sonar_medidor_bcd.sv
// HC-SR04 front end: trigger pulse, echo timing, direct echo-width to BCD cm
// conversion with round-to-nearest, and timeout detection.
module sonar_medidor_bcd #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input logic                clock,
    input logic                reset,
    sonar_medidor_bcd_if.slave bus
);
    localparam int TW = $clog2(TRIGGER_CYCLES + 1);
    localparam int SW = $clog2(CYCLES_PER_CM);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] PREPARACAO = 4'd1;
    localparam logic [3:0] ENVIA_TRIG = 4'd2;
    localparam logic [3:0] ESPERA     = 4'd3;
    localparam logic [3:0] MEDINDO    = 4'd4;
    localparam logic [3:0] ARMAZENA   = 4'd5;
    localparam logic [3:0] FINAL      = 4'd6;
    localparam logic [3:0] TIMEOUT    = 4'd7;

    localparam logic [SW-1:0] SUB_INI = SW'(CYCLES_PER_CM / 2);
    localparam logic [SW-1:0] SUB_MAX = SW'(CYCLES_PER_CM - 1);

    logic [3:0]       estado, prox;
    logic             echo_s1, echo_s2, echo_d;
    logic [TW-1:0]    trig_cnt;
    logic [OW-1:0]    to_cnt;
    logic [SW-1:0]    sub_cnt;
    logic [2:0][3:0]  acc;
    logic [11:0]      medida_r;
    logic             erro_r;
    logic             echo_sobe, echo_desce, trig_fim, to_fim, avanca;

    // Saturating BCD +1: digit carries ripple upward, 999 holds.
    function automatic logic [2:0][3:0] bcd_inc(input logic [2:0][3:0] v);
        logic [2:0][3:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[0] != 4'd9) r[0] = v[0] + 4'd1;
            else begin
                r[0] = 4'd0;
                if (v[1] != 4'd9) r[1] = v[1] + 4'd1;
                else begin
                    r[1] = 4'd0;
                    r[2] = v[2] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign echo_sobe  = echo_s2 & ~echo_d;
    assign echo_desce = ~echo_s2 & echo_d;
    assign trig_fim   = (trig_cnt == TW'(TRIGGER_CYCLES - 1));
    assign to_fim     = (to_cnt == OW'(TIMEOUT_CYCLES - 1));
    // The rise cycle already carries a high synced sample, so it counts too.
    assign avanca     = (estado == ESPERA) ? (echo_sobe & ~to_fim)
                      : (estado == MEDINDO) ? (echo_s2 & ~to_fim) : 1'b0;

    // Echo synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // Next-state logic; timeout wins over a coincident echo edge.
    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:    if (bus.medir) prox = PREPARACAO;
            PREPARACAO: prox = ENVIA_TRIG;
            ENVIA_TRIG: if (trig_fim) prox = ESPERA;
            ESPERA:     if (to_fim) prox = TIMEOUT;
                        else if (echo_sobe) prox = MEDINDO;
            MEDINDO:    if (to_fim) prox = TIMEOUT;
                        else if (echo_desce) prox = ARMAZENA;
            ARMAZENA:   prox = FINAL;
            FINAL:      prox = INICIAL;
            TIMEOUT:    prox = INICIAL;
            default:    prox = INICIAL;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox;
    end

    // Counters, BCD accumulator and result/flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_cnt <= '0;
            to_cnt   <= '0;
            sub_cnt  <= '0;
            acc      <= '0;
            medida_r <= '0;
            erro_r   <= 1'b0;
        end else begin
            case (estado)
                PREPARACAO: begin
                    trig_cnt <= '0;
                    to_cnt   <= '0;
                    sub_cnt  <= SUB_INI;
                    acc      <= '0;
                    erro_r   <= 1'b0;
                end
                ENVIA_TRIG: trig_cnt <= trig_cnt + TW'(1);
                ESPERA, MEDINDO: begin
                    to_cnt <= to_cnt + OW'(1);
                    if (to_fim) erro_r <= 1'b1;
                    if (avanca) begin
                        if (sub_cnt == SUB_MAX) begin
                            sub_cnt <= '0;
                            acc     <= bcd_inc(acc);
                        end else begin
                            sub_cnt <= sub_cnt + SW'(1);
                        end
                    end
                end
                ARMAZENA: medida_r <= acc;
                default: ;
            endcase
        end
    end

    assign bus.trigger   = (estado == ENVIA_TRIG);
    assign bus.pronto    = (estado == FINAL) || (estado == TIMEOUT);
    assign bus.medida    = medida_r;
    assign bus.erro      = erro_r;
    assign bus.db_estado = estado;
endmodule

// File: tb/tb_sonar_medidor_bcd.sv
// Bench for sonar_medidor_bcd: two channels (short and long timeout) with a
// scoreboard fed by the stimulus and drained by a pronto-driven monitor.
module tb_sonar_medidor_bcd;
    localparam int TC  = 5;
    localparam int CPM = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sonar_medidor_bcd_if bus0 ();
    sonar_medidor_bcd_if bus1 ();

    sonar_medidor_bcd #(.TRIGGER_CYCLES(TC), .CYCLES_PER_CM(CPM), .TIMEOUT_CYCLES(2000))
        dut0 (.clock(clock), .reset(reset), .bus(bus0));
    sonar_medidor_bcd #(.TRIGGER_CYCLES(TC), .CYCLES_PER_CM(CPM), .TIMEOUT_CYCLES(20000))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    logic        medir_a [2];
    logic        echo_a  [2];
    logic        trig_a  [2];
    logic        pronto_a[2];
    logic        erro_a  [2];
    logic [11:0] medida_a[2];
    logic [3:0]  db_a    [2];

    assign bus0.medir = medir_a[0];
    assign bus0.echo  = echo_a[0];
    assign bus1.medir = medir_a[1];
    assign bus1.echo  = echo_a[1];
    assign trig_a[0] = bus0.trigger;  assign trig_a[1] = bus1.trigger;
    assign pronto_a[0] = bus0.pronto; assign pronto_a[1] = bus1.pronto;
    assign erro_a[0] = bus0.erro;     assign erro_a[1] = bus1.erro;
    assign medida_a[0] = bus0.medida; assign medida_a[1] = bus1.medida;
    assign db_a[0] = bus0.db_estado;  assign db_a[1] = bus1.db_estado;

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];
    logic [11:0] last_m[2];

    // Reference: round-to-nearest cm, saturated at 999, shown as decimal digits.
    function automatic logic [11:0] ref_bcd(input int n);
        int cm;
        cm = (n + CPM / 2) / CPM;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input logic e, input logic [11:0] m);
        if (i == 0) exp_q0.push_back({e, m});
        else        exp_q1.push_back({e, m});
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic wait_trig_fall(input int i);
        int b;
        b = 0;
        while (!trig_a[i] && b < 20) begin tick(); b++; end
        while (trig_a[i] && b < 40) begin tick(); b++; end
        if (b >= 40 || trig_a[i]) begin
            n_cmp++; n_err++;
            $display("FAIL trig_wait[%0d]: trigger never completed, budget %0d", i, b);
        end
    endtask

    task automatic wait_pronto(input int i, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!pronto_a[i] && cyc < budget);
        if (!pronto_a[i]) begin
            n_cmp++; n_err++;
            $display("FAIL pronto_wait[%0d]: no pronto after %0d cycles", i, cyc);
        end
    endtask

    task automatic start(input int i);
        tick(); medir_a[i] = 1'b1;
        tick(); medir_a[i] = 1'b0;
    endtask

    task automatic echo_pulse(input int i, input int n, input bit poke);
        echo_a[i] = 1'b1;
        for (int c = 0; c < n; c++) begin
            medir_a[i] = poke && (c == n / 2);
            tick();
        end
        echo_a[i] = 1'b0;
        medir_a[i] = 1'b0;
    endtask

    task automatic measure(input int i, input int n, input int dly, input bit poke);
        int c;
        last_m[i] = ref_bcd(n);
        push(i, 1'b0, last_m[i]);
        start(i);
        wait_trig_fall(i);
        chk("erro_clr", int'(erro_a[i]), 0);
        repeat (dly) tick();
        echo_pulse(i, n, poke);
        wait_pronto(i, 100, c);
    endtask

    task automatic meas_timeout(input int i, input int budget);
        int c;
        push(i, 1'b1, last_m[i]);
        start(i);
        wait_trig_fall(i);
        wait_pronto(i, budget, c);
    endtask

    // Monitor: scoreboard pop on pronto, pronto width and medida stability.
    logic        pronto_d[2] = '{1'b0, 1'b0};
    logic [11:0] medida_d[2] = '{12'h0, 12'h0};
    always @(negedge clock) begin
        logic [12:0] e;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (pronto_a[i]) begin
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_unexp[%0d]: pronto with nothing expected, medida %0h", i, medida_a[i]);
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("sb_res[%0d]", i), int'({erro_a[i], medida_a[i]}), int'(e));
                    end
                    if (pronto_d[i]) chk($sformatf("pronto_width[%0d]", i), 2, 1);
                end
                if (medida_a[i] != medida_d[i])
                    chk($sformatf("medida_stable[%0d]", i), int'(pronto_a[i]), 1);
                pronto_d[i] = pronto_a[i];
                medida_d[i] = medida_a[i];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                pronto_d[i] = 1'b0;
                medida_d[i] = 12'h0;
            end
        end
    end

    initial begin : stim
        int c;
        int exp_db[8];
        exp_db = '{0, 1, 2, 2, 2, 2, 2, 3};
        for (int i = 0; i < 2; i++) begin
            medir_a[i] = 1'b0; echo_a[i] = 1'b0; last_m[i] = 12'h000;
        end
        repeat (3) @(posedge clock);
        #2;
        chk("rst_out", int'({trig_a[0], medida_a[0], pronto_a[0], erro_a[0], db_a[0]}), 0);
        tick(); reset = 1'b1;

        // Reset in the middle of an echo.
        start(0);
        wait_trig_fall(0);
        tick(); echo_a[0] = 1'b1;
        repeat (20) tick();
        chk("rst_pre_db", int'(db_a[0]), 4);
        #3 reset = 1'b0;
        #1 chk("rst_async", int'({trig_a[0], medida_a[0], pronto_a[0], erro_a[0], db_a[0]}), 0);
        echo_a[0] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("rst_idle_db", int'(db_a[0]), 0);

        // Trigger shape and state sequence, then no echo -> timeout window.
        push(0, 1'b1, last_m[0]);
        tick(); medir_a[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk($sformatf("seq_db[%0d]", k), int'(db_a[0]), exp_db[k]);
            chk($sformatf("seq_trig[%0d]", k), int'(trig_a[0]), int'(exp_db[k] == 2));
            tick(); medir_a[0] = 1'b0;
        end
        wait_pronto(0, 2100, c);
        chk("to_window", c, 2000);

        // Rounding, carry, timeout keeping the previous result.
        measure(0, 1234, 3, 1'b0);
        measure(0, 125, 0, 1'b1);
        measure(0, 4, 7, 1'b0);
        measure(0, 995, 2, 1'b0);
        meas_timeout(0, 2100);
        measure(0, 1, 0, 1'b0);
        measure(0, 5, 0, 1'b0);
        measure(0, 14, 1, 1'b0);
        measure(0, 15, 1, 1'b0);

        // Randomised widths, gaps and stray medir pulses.
        for (int r = 0; r < 12; r++)
            measure(0, int'($urandom_range(1, 1500)), int'($urandom_range(0, 40)),
                    bit'($urandom_range(0, 1)));

        // Long channel: saturation, then back-to-back with medir held.
        last_m[1] = ref_bcd(15000);
        push(1, 1'b0, last_m[1]);
        tick(); medir_a[1] = 1'b1;
        wait_trig_fall(1);
        tick();
        echo_a[1] = 1'b1;
        repeat (15000) tick();
        echo_a[1] = 1'b0;
        wait_pronto(1, 100, c);
        @(negedge clock); chk("b2b_ini", int'(db_a[1]), 0);
        @(negedge clock); chk("b2b_prep", int'(db_a[1]), 1);
        c = int'($urandom_range(100, 3000));
        last_m[1] = ref_bcd(c);
        push(1, 1'b0, last_m[1]);
        wait_trig_fall(1);
        medir_a[1] = 1'b0;
        tick();
        echo_a[1] = 1'b1;
        for (int k = 0; k < c; k++) begin
            medir_a[1] = (k % 97) == 50;
            tick();
        end
        echo_a[1] = 1'b0;
        medir_a[1] = 1'b0;
        wait_pronto(1, 100, c);
        repeat (3) @(negedge clock);
        chk("b2b_norestart", int'(db_a[1]), 0);

        repeat (5) tick();
        chk("sb_drain0", exp_q0.size(), 0);
        chk("sb_drain1", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
